// File: rtl/stream_demux_4_pkg.sv
// Shared channel count and index type for the 1:4 stream demux.
package demux_pkg;
    localparam int unsigned N_CH = 4;

    typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/stream_demux_4_if.sv
// Producer-side and consumer-side handshake bundle for stream_demux_4.
interface stream_demux_4_if
    import demux_pkg::*;
#(
    parameter int unsigned W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_data;
    ch_idx_t             sel;
    logic                rr_en;
    logic [N_CH-1:0]     out_valid;
    logic [N_CH-1:0]     out_ready;
    logic [N_CH*W-1:0]   out_data;
    ch_idx_t             rr_ptr;

    modport slave (
        input  in_valid, in_data, sel, rr_en, out_ready,
        output in_ready, out_valid, out_data, rr_ptr
    );

    modport master (
        output in_valid, in_data, sel, rr_en, out_ready,
        input  in_ready, out_valid, out_data, rr_ptr
    );
endinterface

// File: rtl/stream_demux_4_fifo.sv
// Two-entry FIFO with registered head; full blocks push even when popping.
module stream_fifo_2 #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_occ;
    logic         w_push_ok;
    logic         w_pop_ok;

    assign full      = (r_occ == 2'd2);
    assign empty     = (r_occ == 2'd0);
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign head_data = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (w_push_ok) r_wptr <= ~r_wptr;
            if (w_pop_ok)  r_rptr <= ~r_rptr;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: rtl/stream_demux_4.sv
// Routes one valid/ready stream to one of four buffered channels, by index or round robin.
module stream_demux_4
    import demux_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    stream_demux_4_if.slave   bus
);
    ch_idx_t         w_dst;
    ch_idx_t         r_rr_ptr;
    logic [N_CH-1:0] w_full;
    logic [N_CH-1:0] w_empty;
    logic [N_CH-1:0] w_push;
    logic [N_CH-1:0] w_pop;
    logic            w_accept;

    if (DEPTH != 2) begin : g_depth_chk
        $fatal(1, "stream_demux_4 supports DEPTH = 2 only");
    end

    // in_ready looks only at occupancy, so it never waits on out_ready
    assign w_dst        = bus.rr_en ? r_rr_ptr : bus.sel;
    assign bus.in_ready = ~w_full[w_dst];
    assign w_accept     = bus.in_valid & ~w_full[w_dst];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_push[i] = w_accept && (w_dst == ch_idx_t'(i));
        assign w_pop[i]  = bus.out_ready[i] & ~w_empty[i];

        stream_fifo_2 #(
            .W (W)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (w_push[i]),
            .push_data (bus.in_data),
            .pop       (w_pop[i]),
            .head_data (bus.out_data[i*W +: W]),
            .full      (w_full[i]),
            .empty     (w_empty[i])
        );
    end

    assign bus.out_valid = ~w_empty;
    assign bus.rr_ptr    = r_rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept && bus.rr_en) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end
    end
endmodule

// File: tb/tb_stream_demux_4.sv
// Directed bench for stream_demux_4: routing, backpressure, round robin, stall and reset.
module tb_stream_demux_4;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic        p_pend = 1'b0;
    logic [6:0]  p_word = '0;

    stream_demux_4_if #(.W(4)) bus ();

    stream_demux_4 #(.W(4), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] slice(input int i);
        return bus.out_data[i*4 +: 4];
    endfunction

    // Checks the producer-side hold rule, then advances one clock and samples #1 later.
    task automatic tick();
        #1;
        if (p_pend && !rst) begin
            chk("hold_valid", 32'(bus.in_valid), 32'd1);
            chk("hold_word", 32'({bus.sel, bus.rr_en, bus.in_data}), 32'(p_word));
        end
        p_pend = bus.in_valid && !bus.in_ready && !rst;
        p_word = {bus.sel, bus.rr_en, bus.in_data};
        @(posedge clk);
        #1;
    endtask

    logic [1:0] sv [4];
    logic [3:0] dv [4];

    initial begin
        sv = '{2'd2, 2'd0, 2'd3, 2'd1};
        dv = '{4'hA, 4'h5, 4'hF, 4'h3};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sel       = '0;
        bus.rr_en     = 1'b0;
        bus.out_ready = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_rr_ptr", 32'(bus.rr_ptr), 32'd0);

        // Indexed routing, back to back
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.sel      = sv[i];
            bus.in_data  = dv[i];
            #1;
            chk("idx_in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            chk("idx_out_valid", 32'(bus.out_valid), 32'(1 << sv[i]));
            chk("idx_data", 32'(slice(int'(sv[i]))), 32'(dv[i]));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("idx_drained", 32'(bus.out_valid), 32'h0);

        // Backpressure on ch0 only
        bus.out_ready = 4'b1110;
        bus.in_valid  = 1'b1;
        bus.sel       = 2'd0;
        bus.in_data   = 4'hA;
        #1;
        chk("bp_ready_a", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_data = 4'hB;
        #1;
        chk("bp_ready_b", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_data = 4'hC;
        #1;
        chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("bp_valid", 32'(bus.out_valid), 32'b0001);
        chk("bp_head_a", 32'(slice(0)), 32'hA);
        chk("bp_still_full", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 4'b1111;
        #1;
        chk("bp_no_comb_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("bp_head_b", 32'(slice(0)), 32'hB);
        chk("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
        tick();
        chk("bp_valid_c", 32'(bus.out_valid), 32'b0001);
        chk("bp_head_c", 32'(slice(0)), 32'hC);
        bus.sel     = 2'd1;
        bus.in_data = 4'h7;
        #1;
        chk("bp_ready_ch1", 32'(bus.in_ready), 32'd1);
        tick();
        chk("bp_valid_ch1", 32'(bus.out_valid), 32'b0010);
        chk("bp_data_ch1", 32'(slice(1)), 32'h7);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_drained", 32'(bus.out_valid), 32'h0);

        // Round robin, 6 words
        bus.rr_en    = 1'b1;
        bus.sel      = 2'd3;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_data = 4'(k + 1);
            #1;
            chk("rr_ready", 32'(bus.in_ready), 32'd1);
            tick();
            chk("rr_valid", 32'(bus.out_valid), 32'(1 << (k % 4)));
            chk("rr_data", 32'(slice(k % 4)), 32'(k + 1));
        end
        chk("rr_ptr_end", 32'(bus.rr_ptr), 32'd2);
        bus.in_valid = 1'b0;
        tick();
        chk("rr_ptr_hold", 32'(bus.rr_ptr), 32'd2);

        // RR stall with all consumers blocked, from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 4'b0000;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_data = 4'(k + 1);
            #1;
            chk("st_ready", 32'(bus.in_ready), 32'd1);
            tick();
        end
        bus.in_data = 4'h9;
        #1;
        chk("st_rr_ptr8", 32'(bus.rr_ptr), 32'd0);
        chk("st_all_valid", 32'(bus.out_valid), 32'hF);
        chk("st_blocked", 32'(bus.in_ready), 32'd0);
        chk("st_heads", 32'({slice(3), slice(2), slice(1), slice(0)}), 32'h4321);
        tick();
        chk("st_wait_ptr", 32'(bus.rr_ptr), 32'd0);
        chk("st_wait_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 4'b0001;
        tick();
        bus.out_ready = 4'b0000;
        chk("st_head5", 32'(slice(0)), 32'h5);
        #1;
        chk("st_ready9", 32'(bus.in_ready), 32'd1);
        tick();
        chk("st_ptr9", 32'(bus.rr_ptr), 32'd1);
        bus.in_data = 4'hA;
        #1;
        chk("st_blocked10", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 4'b0001;
        tick();
        bus.out_ready = 4'b0000;
        chk("st_head9", 32'(slice(0)), 32'h9);
        chk("st_valid_after", 32'(bus.out_valid), 32'hF);

        // Mid-operation reset with ch1 full
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("mr_out_valid", 32'(bus.out_valid), 32'h0);
        chk("mr_rr_ptr", 32'(bus.rr_ptr), 32'd0);
        bus.rr_en    = 1'b0;
        bus.sel      = 2'd1;
        bus.in_data  = 4'hC;
        bus.in_valid = 1'b1;
        #1;
        chk("mr_ready", 32'(bus.in_ready), 32'd1);
        tick();
        chk("mr_valid", 32'(bus.out_valid), 32'b0010);
        chk("mr_data", 32'(slice(1)), 32'hC);
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0010;
        tick();
        chk("mr_no_stale", 32'(bus.out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_demux_4.md
Name: stream_demux_4

Overview:
- Inverse of the 4:1 index mux: one valid/ready input stream is distributed to one of four output channels.
- Destination comes from an explicit 2-bit index (`sel`), or from an internal round-robin pointer when `rr_en` = 1.
- Each output channel has its own 2-entry FIFO. A stalled consumer therefore blocks only traffic addressed to its own channel.
- Sits between a single producer and four independent consumers in the lab datapath.

Parameters:
- W, 4, data width of input and of each output channel.
- DEPTH, 2, entries per channel FIFO; fixed at 2, and the implementation need not support other values.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  W  input word.
- sel  input  2  destination channel index; used when rr_en = 0.
- rr_en  input  1  1 = ignore sel and use the internal round-robin pointer.
- out_valid  output  4  bit i: channel i holds a word.
- out_ready  input  4  bit i: consumer i takes the word.
- out_data  output  4*W  channel i occupies bits [i*W +: W].
- rr_ptr  output  2  current round-robin pointer, for observability.

Behaviour:
- Reset (rst = 1 at posedge):
  - all FIFOs empty, so out_valid = 4'b0000;
  - rr_ptr = 0;
  - out_data is don't-care while the matching out_valid = 0; the bench must not check it.
  - Reset mid-operation discards all buffered words. Nothing is replayed.
- Destination: dst = rr_en ? rr_ptr : sel. This is combinational and sampled only in the same cycle as in_valid.
- Input handshake:
  - in_ready = !full[dst].
  - Accept occurs when in_valid & in_ready at posedge; the word is pushed into FIFO[dst].
  - in_ready must not depend combinationally on out_ready. A full FIFO never accepts, even if it pops in the same cycle.
- Input protocol rule: once in_valid is asserted, in_data, sel and rr_en must stay stable until accepted. The bench asserts this; the DUT does not check it.
- Round-robin pointer:
  - rr_ptr advances by 1, wrapping 3 -> 0, only on an accepted transfer while rr_en = 1.
  - It holds otherwise, including when rr_en = 0. There is no skipping of full channels: rr mode stalls on a full target (strict order).
- Output handshake per channel i:
  - out_valid[i] = !empty[i]; out_data slice i = FIFO head.
  - A pop occurs when out_valid[i] & out_ready[i].
  - out_valid and out_data come straight from FIFO registers, with no combinational path from in_*.
- Latency: a word accepted at edge k is visible on out_valid/out_data at edge k (valid in the cycle after the accept cycle). Minimum latency is 1 cycle.
- Throughput: 1 word/cycle into a channel whose consumer holds out_ready = 1 continuously.
- Simultaneous push and pop on the same non-full FIFO: both happen and occupancy is unchanged.
  - With 1 entry: head pops, the new word becomes head, and out_valid stays 1.
  - With 0 entries: a pop is impossible (out_valid = 0), so it is a push only.
- Ordering: words are FIFO-ordered within a channel. There is no ordering guarantee across channels.
- Full and empty per FIFO:
  - occupancy 0..2; full = (occ == 2); empty = (occ == 0).
  - Write and read pointers are 1 bit each and wrap naturally.

Decomposition:
- Package demux_pkg:
  - localparam N_CH = 4;
  - typedef logic [1:0] ch_idx_t, used for sel, rr_ptr and dst.
- Sub-module stream_fifo_2: parameter W. Ports clk, rst, push, push_data, pop, head_data, full, empty.
- Top level: instantiate it 4 times with a generate loop, plus the dst mux, the push decode, and rr_ptr.

Test Plan:
- Reset then idle: rst 2 cycles -> out_valid = 0000, in_ready = 1, rr_ptr = 0.
- Indexed routing: rr_en = 0, out_ready = 1111, send (sel, data) = (2, 4'hA), (0, 4'h5), (3, 4'hF), (1, 4'h3) back to back.
  - Each appears 1 cycle later on exactly its channel: e.g. out_valid = 0100 with slice2 = A.
  - Zero stall cycles.
- Backpressure isolation: out_ready = 1110, send 3 words to ch0 then 1 word to ch1.
  - ch0 accepts 2 words (A, B).
  - in_ready drops while the third word targets ch0; sel cannot change until it is accepted.
  - Raising out_ready[0] releases the words in order A, B, C.
  - Then the ch1 word is delivered.
- Round robin: rr_en = 1, out_ready = 1111, send 6 words 1..6.
  - Channels receive, in order: ch0: 1, 5; ch1: 2, 6; ch2: 3; ch3: 4.
  - rr_ptr ends at 2.
- RR stall: rr_en = 1, out_ready = 0000, send 10 words.
  - 8 words are accepted (2 per channel), then in_ready = 0.
  - rr_ptr = 0 after the 8 accepts; the 9th word waits.
  - Set out_ready = 0001: the 9th word enters ch0.
- Mid-operation reset: fill ch1 with 2 words, assert rst 1 cycle.
  - out_valid = 0000 and rr_ptr = 0 the next cycle.
  - A new word to ch1 appears alone, with none of the old data.
